// File: rtl/fxp_decim_accumulator.sv
// fxp_decim_accumulator
// Sums each frame of `osr` valid fixed-point samples, rounds the frame sum
// half-up into the output format and emits it with a one-cycle valid pulse.
// Build option: define FXP_DECIM_SATURATE_EN to clamp out-of-range results
// to the most positive / most negative output code; otherwise the result
// wraps (low bits kept).
module fxp_decim_accumulator #(
    parameter int n_int_in   = 8,
    parameter int n_mant_in  = 23,
    parameter int n_int_out  = 8,
    parameter int n_mant_out = 23,
    parameter int osr        = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr,
    input  logic [n_int_in+n_mant_in:0]       in,
    input  logic                              in_valid,
    output logic [n_int_out+n_mant_out:0]     out,
    output logic                              out_valid
);

    localparam int N_G       = $clog2(osr);
    localparam int N_TOT_IN  = n_int_in + n_mant_in;
    localparam int N_TOT_OUT = n_int_out + n_mant_out;
    localparam int ACC_W     = N_TOT_IN + 1 + N_G;
    localparam int OUT_W     = N_TOT_OUT + 1;
    // Left shift amount when the output has more fractional bits than the input
    localparam int LSH       = (n_mant_out > n_mant_in) ? (n_mant_out - n_mant_in) : 0;
    // Converted value width: sum plus one guard bit for the rounding add, plus any left shift
    localparam int CONV_W    = ACC_W + 1 + LSH;

    localparam logic [N_G-1:0] CNT_LAST = N_G'(osr - 1);
    localparam logic [N_G-1:0] CNT_ONE  = N_G'(1'b1);

    logic signed [ACC_W-1:0]  r_acc;
    logic        [N_G-1:0]    r_cnt;
    logic        [OUT_W-1:0]  r_out;
    logic                     r_out_valid;

    logic signed [ACC_W-1:0]  w_in_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic                     w_last;
    logic signed [CONV_W-1:0] w_conv;
    logic        [OUT_W-1:0]  w_out_next;

    // Sign-extend the sample into the guard-bit-widened accumulator format;
    // osr samples can never overflow this width.
    assign w_in_ext = {{N_G{in[N_TOT_IN]}}, in};
    assign w_sum    = r_acc + w_in_ext;
    assign w_last   = (r_cnt == CNT_LAST);

    generate
        if (n_mant_out < n_mant_in) begin : g_round
            localparam int SH = n_mant_in - n_mant_out;
            localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1'b1) <<< (SH - 1);
            logic signed [ACC_W:0] w_wide;
            logic signed [ACC_W:0] w_rnd_add;
            // One extra bit so the half-LSB add cannot overflow
            assign w_wide    = {w_sum[ACC_W-1], w_sum};
            assign w_rnd_add = w_wide + HALF;
            // Arithmetic shift after adding half: round-half-up (ties toward +inf)
            assign w_conv    = w_rnd_add >>> SH;
        end else begin : g_shift
            logic signed [CONV_W-1:0] w_ext;
            // More output fractional bits: exact sign-extended left shift
            assign w_ext  = CONV_W'(w_sum);
            assign w_conv = w_ext <<< LSH;
        end
    endgenerate

    generate
        if (CONV_W > OUT_W) begin : g_narrow
`ifdef FXP_DECIM_SATURATE_EN
            localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
            localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
            logic [CONV_W-OUT_W:0] w_hi;
            logic                  w_ovf;
            // In range only when all bits above the output sign bit equal it
            assign w_hi  = w_conv[CONV_W-1:OUT_W-1];
            assign w_ovf = ~((&w_hi) | ~(|w_hi));
            // Clamp toward the sign of the unclamped value when out of range
            always_comb begin
                w_out_next = w_conv[OUT_W-1:0];
                if (w_ovf) begin
                    if (w_conv[CONV_W-1]) begin
                        w_out_next = OUT_MIN;
                    end else begin
                        w_out_next = OUT_MAX;
                    end
                end else begin
                    w_out_next = w_conv[OUT_W-1:0];
                end
            end
`else
            logic w_unused_hi;
            // Two's-complement wrap: keep only the low output bits
            assign w_out_next  = w_conv[OUT_W-1:0];
            assign w_unused_hi = ^w_conv[CONV_W-1:OUT_W];
`endif
        end else begin : g_widen
            // Output is at least as wide: plain sign extension
            assign w_out_next = OUT_W'(w_conv);
        end
    endgenerate

    // Frame accumulation, counter and registered output update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= {ACC_W{1'b0}};
            r_cnt       <= {N_G{1'b0}};
            r_out       <= {OUT_W{1'b0}};
            r_out_valid <= 1'b0;
        end else if (clr) begin
            r_acc       <= {ACC_W{1'b0}};
            r_cnt       <= {N_G{1'b0}};
            r_out_valid <= 1'b0;
        end else if (in_valid) begin
            if (w_last) begin
                r_acc       <= {ACC_W{1'b0}};
                r_cnt       <= {N_G{1'b0}};
                r_out       <= w_out_next;
                r_out_valid <= 1'b1;
            end else begin
                r_acc       <= w_sum;
                r_cnt       <= r_cnt + CNT_ONE;
                r_out_valid <= 1'b0;
            end
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_fxp_decim_accumulator.sv
// Directed bench for fxp_decim_accumulator: Q3.4 input, 4-sample frames.
// Instance u_dut8 has a Q5.2 (8-bit) output; u_dut6 has a Q3.2 (6-bit)
// output, used for the out-of-range wrap/saturate cases.
module tb_fxp_decim_accumulator;

    logic       clk;
    logic       rst;
    logic       clr;
    logic [7:0] s_in;
    logic       s_in_valid;
    logic [7:0] out8;
    logic       ov8;
    logic [5:0] out6;
    logic       ov6;

    int n_tests;
    int n_fail;

    fxp_decim_accumulator #(
        .n_int_in(3), .n_mant_in(4), .n_int_out(5), .n_mant_out(2), .osr(4)
    ) u_dut8 (
        .clk(clk), .rst(rst), .clr(clr), .in(s_in), .in_valid(s_in_valid),
        .out(out8), .out_valid(ov8)
    );

    fxp_decim_accumulator #(
        .n_int_in(3), .n_mant_in(4), .n_int_out(3), .n_mant_out(2), .osr(4)
    ) u_dut6 (
        .clk(clk), .rst(rst), .clr(clr), .in(s_in), .in_valid(s_in_valid),
        .out(out6), .out_valid(ov6)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int val);
        s_in       = 8'(val);
        s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
    endtask

    task automatic send_n(input int val, input int n);
        for (int i = 0; i < n; i++) send(val);
    endtask

    task automatic pulse_clr(input logic with_valid, input int val);
        clr        = 1'b1;
        s_in       = 8'(val);
        s_in_valid = with_valid;
        tick();
        clr        = 1'b0;
        s_in_valid = 1'b0;
    endtask

    // Expected result of the 6-bit instance when the frame sum overflows it
    function automatic int exp6(input int sat_val, input int wrap_val);
`ifdef FXP_DECIM_SATURATE_EN
        return sat_val;
`else
        return wrap_val;
`endif
    endfunction

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        clr        = 1'b0;
        s_in       = 8'd0;
        s_in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_out8", $signed(out8), 0);
        check("reset_ov8", int'(ov8), 0);
        check("reset_out6", $signed(out6), 0);

        // 1: four samples of 1.0 -> 4.0
        send_n(16, 3);
        check("t1_no_early_valid", int'(ov8), 0);
        send(16);
        check("t1_ov", int'(ov8), 1);
        check("t1_out8", $signed(out8), 16);
        check("t1_out6", $signed(out6), 16);
        check("t1_ov6", int'(ov6), 1);
        tick();
        check("t1_ov_one_cycle", int'(ov8), 0);
        check("t1_out_hold", $signed(out8), 16);

        // 2: rounding, back-to-back frames
        send(1); send(1); send(0); send(0);
        check("t2_pos_tie_below", $signed(out8), 1);
        send(-1); send(-1); send(0); send(0);
        check("t2_neg_half", $signed(out8), 0);
        send_n(2, 4);
        check("t2_half_up", $signed(out8), 2);
        check("t2_ov", int'(ov8), 1);

        // 3: gaps between valid samples
        for (int k = 0; k < 4; k++) begin
            send(16);
            if (k < 3) begin
                for (int g = 0; g < 3; g++) begin
                    check("t3_gap_no_valid", int'(ov8), 0);
                    tick();
                end
            end
        end
        check("t3_ov", int'(ov8), 1);
        check("t3_out8", $signed(out8), 16);
        tick();
        check("t3_ov_drop", int'(ov8), 0);

        // 4: clear discards the partial frame
        send_n(16, 2);
        pulse_clr(1'b0, 0);
        check("t4_clr_ov", int'(ov8), 0);
        check("t4_clr_out_hold", $signed(out8), 16);
        send_n(8, 4);
        check("t4_out8", $signed(out8), 8);
        check("t4_ov", int'(ov8), 1);
        pulse_clr(1'b1, 64);
        send_n(4, 3);
        check("t4_clr_sample_not_counted", int'(ov8), 0);
        send(4);
        check("t4_after_clr_valid", int'(ov8), 1);
        check("t4_after_clr_out", $signed(out8), 4);
        send_n(16, 3);
        pulse_clr(1'b1, 16);
        check("t4_clr_on_close_ov", int'(ov8), 0);
        check("t4_clr_on_close_out", $signed(out8), 4);
        send_n(16, 4);
        check("t4_next_frame_out", $signed(out8), 16);

        // 5: reset mid-frame
        send_n(8, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_out8", $signed(out8), 0);
        check("t5_rst_ov", int'(ov8), 0);
        send_n(16, 3);
        check("t5_cnt_restart", int'(ov8), 0);
        send(16);
        check("t5_out8", $signed(out8), 16);
        check("t5_ov", int'(ov8), 1);

        // 6: range extremes; 6-bit instance overflows
        send_n(127, 4);
        check("t6_pos_out8", $signed(out8), 127);
        check("t6_pos_out6", $signed(out6), exp6(31, -1));
        send_n(-128, 4);
        check("t6_neg_out8", $signed(out8), -128);
        check("t6_neg_out6", $signed(out6), exp6(-32, 0));
        check("t6_ov6", int'(ov6), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
